// File: rtl/gesture_sequencer.sv
// rtl/gesture_sequencer.sv - programmable gesture playback controller with live passthrough
//
// Stores up to DEPTH steps of (8-bit gesture code, hold time in ticks) and
// replays them into the gesture decoder. While idle, it forwards the live
// manual gesture one cycle later.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   wr_en          step memory write strobe (accepted in every state)
//   wr_addr        step index to write
//   wr_gesture     gesture code to store
//   wr_hold        hold time (ticks) to store
//   seq_len        steps to play, clamped to DEPTH, sampled on start
//   start          pulse: (re)start playback at step 0
//   stop           pulse: abort playback; has priority over start
//   loop_en        wrap to step 0 after the last step
//   manual_gesture live gesture forwarded while idle
//   gesture_out    registered gesture code to the decoder
//   busy           high while playing
//   step_idx       index of the step currently shown
//   done           one-cycle pulse when a non-looping run completes
module gesture_sequencer #(
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 4,
   parameter int HOLD_W   = 16,
   parameter int TICK_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_gesture,
   input  logic [HOLD_W-1:0] wr_hold,
   input  logic [ADDR_W:0]   seq_len,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [7:0]        manual_gesture,
   output logic [7:0]        gesture_out,
   output logic              busy,
   output logic [ADDR_W-1:0] step_idx,
   output logic              done
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_L    = (ADDR_W + 1)'(1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   state_t                 state;
   logic [8+HOLD_W-1:0]    mem [DEPTH];
   logic [8+HOLD_W-1:0]    rd_data;
   logic [ADDR_W-1:0]      rd_addr;
   logic [ADDR_W:0]        len_q;
   logic [ADDR_W:0]        eff_len;
   logic [PRE_W-1:0]       presc;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [7:0]             rd_gesture;
   logic [HOLD_W-1:0]      rd_hold;
   logic                   start_ok;
   logic                   step_end;
   logic                   last_step;

   assign eff_len    = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
   assign start_ok   = start && !stop && (eff_len != '0);
   assign step_end   = (state == HOLD) && (presc == PRE_LAST) && (hold_cnt == HOLD_ONE);
   assign last_step  = ({1'b0, step_idx} == (len_q - ONE_L));
   assign rd_gesture = rd_data[8+HOLD_W-1:HOLD_W];
   assign rd_hold    = rd_data[HOLD_W-1:0];

   // The read is issued on the edge that enters LOAD, addressed by the step
   // about to be loaded, so the data is ready when LOAD ends.
   always_comb begin
      rd_addr = step_idx;
      if (start_ok)
         rd_addr = '0;
      else if (step_end)
         rd_addr = last_step ? '0 : step_idx + 1'b1;
   end

   // Non-blocking read/write gives read-before-write on address collision.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= {wr_gesture, wr_hold};
      rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         gesture_out <= '0;
         busy        <= 1'b0;
         step_idx    <= '0;
         done        <= 1'b0;
         presc       <= '0;
         hold_cnt    <= '0;
         len_q       <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE)
            gesture_out <= manual_gesture;

         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (start_ok) begin
            len_q    <= eff_len;
            step_idx <= '0;
            state    <= LOAD;
            busy     <= 1'b1;
         end else begin
            case (state)
               LOAD: begin
                  gesture_out <= rd_gesture;
                  hold_cnt    <= (rd_hold == '0) ? HOLD_ONE : rd_hold;
                  presc       <= '0;
                  state       <= HOLD;
               end
               HOLD: begin
                  if (presc == PRE_LAST) begin
                     presc    <= '0;
                     hold_cnt <= hold_cnt - 1'b1;
                     if (hold_cnt == HOLD_ONE) begin
                        if (!last_step) begin
                           step_idx <= step_idx + 1'b1;
                           state    <= LOAD;
                        end else if (loop_en) begin
                           step_idx <= '0;
                           state    <= LOAD;
                        end else begin
                           done  <= 1'b1;
                           busy  <= 1'b0;
                           state <= IDLE;
                        end
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gesture_sequencer.sv
// tb/tb_gesture_sequencer.sv - directed self-checking bench for gesture_sequencer
module tb_gesture_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_gesture;
   logic [15:0] wr_hold;
   logic [4:0]  seq_len;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [7:0]  manual_gesture;
   logic [7:0]  gesture_out;
   logic        busy;
   logic [3:0]  step_idx;
   logic        done;

   int tests = 0;
   int fails = 0;

   gesture_sequencer #(
      .DEPTH(16), .ADDR_W(4), .HOLD_W(16), .TICK_DIV(4)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_gesture(wr_gesture), .wr_hold(wr_hold), .seq_len(seq_len),
      .start(start), .stop(stop), .loop_en(loop_en),
      .manual_gesture(manual_gesture), .gesture_out(gesture_out),
      .busy(busy), .step_idx(step_idx), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] g, input logic [15:0] h);
      wr_en = 1'b1; wr_addr = a; wr_gesture = g; wr_hold = h;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_gesture = '0; wr_hold = '0;
      seq_len = '0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; manual_gesture = 8'h00;
      tick(); tick();
      chk("rst_gesture", gesture_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", step_idx, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;

      // basic playback
      manual_gesture = 8'hA5;
      tick();
      chk("idle_pass", gesture_out, 8'hA5);
      wr(4'd0, 8'h11, 16'd2);
      wr(4'd1, 8'h22, 16'd1);
      seq_len = 5'd2; loop_en = 1'b0;
      pulse_start();
      chk("b_c1_busy", busy, 1);
      chk("b_c1_gest", gesture_out, 8'hA5);
      tick();
      chk("b_c2_gest", gesture_out, 8'h11);
      repeat (8) tick();
      chk("b_c10_gest", gesture_out, 8'h11);
      chk("b_c10_idx", step_idx, 1);
      tick();
      chk("b_c11_gest", gesture_out, 8'h22);
      repeat (3) tick();
      chk("b_c14_busy", busy, 1);
      chk("b_c14_done", done, 0);
      tick();
      chk("b_c15_done", done, 1);
      chk("b_c15_busy", busy, 0);
      chk("b_c15_gest", gesture_out, 8'h22);
      tick();
      chk("b_c16_done", done, 0);
      chk("b_c16_gest", gesture_out, 8'hA5);

      // looping, then clear loop_en before the second wrap
      loop_en = 1'b1;
      pulse_start();
      tick();
      repeat (13) tick();
      chk("l_c15_busy", busy, 1);
      chk("l_c15_done", done, 0);
      chk("l_c15_idx", step_idx, 0);
      tick();
      chk("l_c16_gest", gesture_out, 8'h11);
      loop_en = 1'b0;
      repeat (12) tick();
      chk("l_c28_done", done, 0);
      tick();
      chk("l_c29_done", done, 1);
      chk("l_c29_busy", busy, 0);
      tick();

      // zero hold behaves as one tick
      wr(4'd0, 8'h33, 16'd0);
      seq_len = 5'd1;
      pulse_start();
      tick();
      chk("z_c2_gest", gesture_out, 8'h33);
      repeat (3) tick();
      chk("z_c5_busy", busy, 1);
      tick();
      chk("z_c6_done", done, 1);
      tick();

      // zero length start is ignored
      seq_len = 5'd0; manual_gesture = 8'h5A;
      tick();
      pulse_start();
      chk("zl_busy1", busy, 0);
      tick();
      chk("zl_busy2", busy, 0);
      chk("zl_gest", gesture_out, 8'h5A);
      manual_gesture = 8'h3C;
      tick();
      chk("pass_lat", gesture_out, 8'h3C);

      // stop mid-hold
      wr(4'd0, 8'h11, 16'd2);
      seq_len = 5'd2;
      pulse_start();
      repeat (3) tick();
      stop = 1'b1; manual_gesture = 8'h77;
      tick();
      stop = 1'b0;
      chk("s_busy", busy, 0);
      chk("s_done", done, 0);
      chk("s_idx", step_idx, 0);
      chk("s_gest_hold", gesture_out, 8'h11);
      tick();
      chk("s_gest_pass", gesture_out, 8'h77);
      chk("s_done2", done, 0);

      // stop wins over start
      stop = 1'b1; start = 1'b1;
      tick();
      stop = 1'b0; start = 1'b0;
      chk("ss_busy1", busy, 0);
      tick();
      chk("ss_busy2", busy, 0);

      // seq_len clamps to 16 steps
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h40 + i), 16'd1);
      seq_len = 5'd20;
      pulse_start();
      tick();
      chk("c_c2_gest", gesture_out, 8'h40);
      repeat (75) tick();
      chk("c_c77_gest", gesture_out, 8'h4F);
      chk("c_c77_idx", step_idx, 15);
      repeat (3) tick();
      chk("c_c80_busy", busy, 1);
      tick();
      chk("c_c81_done", done, 1);
      chk("c_c81_busy", busy, 0);

      // restart during step 1, then live write of step 1
      wr(4'd0, 8'h11, 16'd2);
      wr(4'd1, 8'h22, 16'd1);
      seq_len = 5'd2;
      pulse_start();
      tick();
      repeat (10) tick();
      chk("r_c12_gest", gesture_out, 8'h22);
      chk("r_c12_idx", step_idx, 1);
      pulse_start();
      chk("r_c13_idx", step_idx, 0);
      chk("r_c13_busy", busy, 1);
      tick();
      chk("r_c14_gest", gesture_out, 8'h11);
      wr_en = 1'b1; wr_addr = 4'd1; wr_gesture = 8'h66; wr_hold = 16'd1;
      tick();
      wr_en = 1'b0;
      repeat (8) tick();
      chk("w_c23_gest", gesture_out, 8'h66);
      chk("w_c23_idx", step_idx, 1);
      repeat (4) tick();
      chk("w_c27_done", done, 1);
      tick();

      // async reset mid-hold, away from the clock edge
      pulse_start();
      repeat (11) tick();
      chk("a_pre_idx", step_idx, 1);
      #2 reset = 1'b1;
      #1;
      chk("a_gest", gesture_out, 0);
      chk("a_busy", busy, 0);
      chk("a_idx", step_idx, 0);
      chk("a_done", done, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("a_pass", gesture_out, 8'h77);
      chk("a_busy2", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
